// File: rtl/camera_rx.sv
`default_nettype none
// ============================================================================
//  Module      : camera_rx
//  Description : Requests words from a camera, captures one word at a time
//                and unpacks it into NPIX pixels on a valid/ready stream
//                with frame coordinates and start/end markers. A sticky
//                flag reports frames whose end marker does not line up with
//                the last pixel position.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            : single clock, all logic on rising edge
//    rst            : synchronous active-high reset
//    recieve_ready  : word request to the camera
//    in_progress    : camera has accepted the request
//    data           : camera word (BUS_WIDTH bits)
//    data_valid     : data holds a valid word
//    frame_end      : level; rising edge marks the last word of a frame
//    pix_data       : pixel, channel 0 in the MSBs
//    pix_valid      : pix_data valid
//    pix_ready      : downstream accepts (transfer on pix_valid & pix_ready)
//    pix_x / pix_y  : column / row of the current pixel
//    pix_sof        : first pixel of frame (qualified by pix_valid)
//    pix_eol        : last pixel of row (qualified by pix_valid)
//    pix_eof        : last pixel of frame (qualified by pix_valid)
//    err_frame_len  : sticky frame-length mismatch flag
// ============================================================================
module camera_rx #(
    parameter int BUS_WIDTH = 96,
    parameter int SHAPE_H   = 480,
    parameter int SHAPE_W   = 848,
    parameter int SHAPE_CH  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       recieve_ready,
    input  logic                       in_progress,
    input  logic [BUS_WIDTH-1:0]       data,
    input  logic                       data_valid,
    input  logic                       frame_end,
    output logic [8*SHAPE_CH-1:0]      pix_data,
    output logic                       pix_valid,
    input  logic                       pix_ready,
    output logic [$clog2(SHAPE_W)-1:0] pix_x,
    output logic [$clog2(SHAPE_H)-1:0] pix_y,
    output logic                       pix_sof,
    output logic                       pix_eol,
    output logic                       pix_eof,
    output logic                       err_frame_len
);

    localparam int PIX_W = 8 * SHAPE_CH;
    localparam int NPIX  = BUS_WIDTH / PIX_W;
    localparam int XW    = $clog2(SHAPE_W);
    localparam int YW    = $clog2(SHAPE_H);
    localparam int KW    = (NPIX > 1) ? $clog2(NPIX) : 1;

    localparam logic [XW-1:0] c_X_LAST = XW'(SHAPE_W - 1);
    localparam logic [YW-1:0] c_Y_LAST = YW'(SHAPE_H - 1);
    localparam logic [KW-1:0] c_K_LAST = KW'(NPIX - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_REQ    = 2'd1;
    localparam logic [1:0] c_WAIT   = 2'd2;
    localparam logic [1:0] c_UNPACK = 2'd3;

    // Reject geometries the unpacker cannot tile exactly.
    generate
        if ((BUS_WIDTH % PIX_W) != 0 || NPIX < 1 ||
            ((SHAPE_H * SHAPE_W) % NPIX) != 0 ||
            SHAPE_W < 2 || SHAPE_H < 2) begin : g_param_check
            $error("camera_rx: unsupported BUS_WIDTH/SHAPE parameters");
        end
    endgenerate

    logic [1:0]           r_state;
    logic [BUS_WIDTH-1:0] r_buf;
    logic [KW-1:0]        r_k;
    logic                 r_word_fe;
    logic                 r_frame_end_d;
    logic [XW-1:0]        r_x;
    logic [YW-1:0]        r_y;
    logic                 r_err;

    logic w_unpack;
    logic w_xfer;
    logic w_x_last;
    logic w_y_last;
    logic w_k_last;
    logic w_frame_last;
    logic w_slot_last;

    assign w_unpack     = (r_state == c_UNPACK);
    assign w_xfer       = w_unpack & pix_ready;
    assign w_x_last     = (r_x == c_X_LAST);
    assign w_y_last     = (r_y == c_Y_LAST);
    assign w_k_last     = (r_k == c_K_LAST);
    assign w_frame_last = w_x_last & w_y_last;
    // The frame's last pixel must be exactly the final slot of the word that
    // carries the frame_end edge; any other pairing is a length mismatch.
    assign w_slot_last  = r_word_fe & w_k_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_buf         <= '0;
            r_k           <= '0;
            r_word_fe     <= 1'b0;
            r_frame_end_d <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_err         <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: r_state <= c_REQ;
                c_REQ: begin
                    if (in_progress) begin
                        r_state <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (data_valid) begin
                        r_buf         <= data;
                        // Edge is taken between consecutive captured words,
                        // so a level held across idle cycles is counted once.
                        r_word_fe     <= frame_end & ~r_frame_end_d;
                        r_frame_end_d <= frame_end;
                        r_k           <= '0;
                        r_state       <= c_UNPACK;
                    end
                end
                c_UNPACK: begin
                    if (w_xfer) begin
                        // Shift so the next pixel always sits in the MSBs.
                        r_buf <= r_buf << PIX_W;
                        r_k   <= r_k + 1'b1;
                        if (w_x_last) begin
                            r_x <= '0;
                            r_y <= w_y_last ? '0 : r_y + 1'b1;
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                        if (w_slot_last != w_frame_last) begin
                            r_err <= 1'b1;
                        end
                        if (w_k_last) begin
                            r_state <= c_REQ;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign recieve_ready = (r_state == c_REQ);
    assign pix_valid     = w_unpack;
    assign pix_data      = r_buf[BUS_WIDTH-1 -: PIX_W];
    assign pix_x         = r_x;
    assign pix_y         = r_y;
    assign pix_sof       = w_unpack & (r_x == '0) & (r_y == '0);
    assign pix_eol       = w_unpack & w_x_last;
    assign pix_eof       = w_unpack & w_x_last & w_y_last;
    assign err_frame_len = r_err;

endmodule
`default_nettype wire

// File: doc/camera_rx.md
CAMERA_RX -- requirements
Module: camera_rx

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 96: width of the camera word bus.
REQ-002 SHALL have parameter SHAPE_H, default 480: frame rows.
REQ-003 SHALL have parameter SHAPE_W, default 848: frame columns.
REQ-004 SHALL have parameter SHAPE_CH, default 3: 8-bit channels per pixel; PIX_W = 8*SHAPE_CH.
REQ-005 SHALL have parameters satisfying BUS_WIDTH % PIX_W == 0 and (SHAPE_H*SHAPE_W) % (BUS_WIDTH/PIX_W) == 0; NPIX = BUS_WIDTH/PIX_W.
REQ-006 clk  in  1  single clock, all logic on posedge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 recieve_ready  out  1  word request to camera.
REQ-009 in_progress  in  1  camera has accepted the request.
REQ-010 data  in  BUS_WIDTH  camera word.
REQ-011 data_valid  in  1  data holds a valid word.
REQ-012 frame_end  in  1  level; rising edge marks the last word of a frame.
REQ-013 pix_data  out  PIX_W  pixel; channel 0 in MSBs.
REQ-014 pix_valid  out  1  pix_data valid.
REQ-015 pix_ready  in  1  downstream accepts; transfer when pix_valid & pix_ready.
REQ-016 pix_x  out  clog2(SHAPE_W)  column of current pixel.
REQ-017 pix_y  out  clog2(SHAPE_H)  row of current pixel.
REQ-018 pix_sof / pix_eol / pix_eof  out  1 each  first pixel of frame / last of row / last of frame, qualified by pix_valid.
REQ-019 err_frame_len  out  1  sticky frame-length mismatch flag.

Function
REQ-020 SHALL implement states IDLE, REQ, WAIT, UNPACK.
REQ-021 IDLE: one cycle after reset release, go to REQ.
REQ-022 REQ: recieve_ready=1; when in_progress=1 sampled, recieve_ready=0 next cycle and go to WAIT.
REQ-023 WAIT: recieve_ready=0; on data_valid=1, register data into a word buffer, register frame_end rising edge (frame_end & ~frame_end_d), go to UNPACK.
REQ-024 data_valid sampled in any state other than WAIT SHALL be ignored (camera holds it high until next request).
REQ-025 UNPACK: present pixel k = buffer[BUS_WIDTH-1-k*PIX_W -: PIX_W], k = 0..NPIX-1, in order; hold pix_data/flags stable while pix_valid & ~pix_ready.
REQ-026 After transfer of pixel NPIX-1, go to REQ in the next cycle; first request therefore overlaps no unpacking (one word in flight max).
REQ-027 pix_x increments per transfer, wraps SHAPE_W-1 -> 0 with pix_y+1; pix_y wraps SHAPE_H-1 -> 0.
REQ-028 pix_sof=1 iff pix_x=0 & pix_y=0; pix_eol=1 iff pix_x=SHAPE_W-1; pix_eof=1 iff pix_eol & pix_y=SHAPE_H-1.
REQ-029 err_frame_len SHALL set if a word flagged with frame_end edge does not contain the pixel at (SHAPE_W-1, SHAPE_H-1) as pixel NPIX-1, or if that pixel arrives in a word without the edge; on error, counters continue (no resync).
REQ-030 Minimum word period: 2 (REQ) + camera latency + 1 (WAIT) + NPIX transfer cycles.

Reset
REQ-031 On rst: state=IDLE, recieve_ready=0, pix_valid=0, pix_data=0, pix_x=0, pix_y=0, flags 0, err_frame_len=0, frame_end_d=0.
REQ-032 rst asserted mid-UNPACK SHALL discard the buffered word; no further pix_valid until a new word arrives.

Verification
REQ-033 BUS_WIDTH=96, 4x4x3 frame, camera model, pix_ready=1 -> 16 pixels in file order, pix_sof on pixel 0, pix_eol on x=3, pix_eof on pixel 15, err_frame_len=0.
REQ-034 Word 0x112233_445566_778899_AABBCC -> pixels 0x112233, 0x445566, 0x778899, 0xAABBCC in that order.
REQ-035 pix_ready toggling 1 cycle on/1 off -> identical pixel sequence, pix_data stable while stalled, recieve_ready never 1 during UNPACK.
REQ-036 frame_end edge injected on 3rd word of 4x4 frame -> err_frame_len=1 after that word, stays 1 until rst.
REQ-037 rst pulsed while pixel 2 of a word is pending -> pix_valid=0 the cycle after, pix_x=pix_y=0, next pixel out is from the next camera word.
REQ-038 Two consecutive 4x4 frames -> pix_x/pix_y wrap to 0, second pix_sof asserted, no error.
